// File: rtl/disparity_wta_pkg.sv
// Shared definitions for the winner-take-all disparity selector.
// Default geometry and the two-state output FSM encodings.
package disparity_wta_pkg;

  localparam int SAD_SIZE_DEF  = 16;
  localparam int MAX_DISP_DEF  = 64;
  localparam int DISP_SIZE_DEF = 6;

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;

endpackage

// File: rtl/disparity_wta_compare.sv
// One step of the running-minimum search; candidate 0 always seeds the search,
// later candidates replace the minimum only when strictly smaller.
module wta_compare #(
  parameter int SAD_SIZE  = 16,
  parameter int DISP_SIZE = 6
) (
  input  logic [SAD_SIZE-1:0]  sad_in,
  input  logic [SAD_SIZE-1:0]  min_cur,
  input  logic [DISP_SIZE-1:0] idx_cur,
  input  logic [DISP_SIZE-1:0] d,
  output logic [SAD_SIZE-1:0]  min_nxt,
  output logic [DISP_SIZE-1:0] idx_nxt
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    min_nxt = min_cur;
    idx_nxt = idx_cur;
    if (d == '0 || sad_in < min_cur) begin
      min_nxt = sad_in;
      idx_nxt = d;
    end
  end

endmodule

// File: rtl/disparity_wta.sv
// Winner-take-all disparity selector: streams MAX_DISP SAD costs per pixel and emits the
// index of the lowest one. Define WTA_COST_EN to also expose the winning cost on disp_cost.
module disparity_wta
  import disparity_wta_pkg::*;
#(
  parameter int SAD_SIZE  = SAD_SIZE_DEF,
  parameter int MAX_DISP  = MAX_DISP_DEF,
  parameter int DISP_SIZE = DISP_SIZE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sad_valid,
  output logic                 sad_ready,
  input  logic [SAD_SIZE-1:0]  sad_in,
  output logic                 disp_valid,
  input  logic                 disp_ready,
  output logic [DISP_SIZE-1:0] disp_out
`ifdef WTA_COST_EN
  ,
  output logic [SAD_SIZE-1:0]  disp_cost
`endif
);

  localparam logic [DISP_SIZE-1:0] LAST_D = DISP_SIZE'(MAX_DISP - 1);

  logic [0:0]           state_q, state_d;
  logic [DISP_SIZE-1:0] cnt_q, cnt_d;
  logic [SAD_SIZE-1:0]  min_q, min_d;
  logic [DISP_SIZE-1:0] idx_q, idx_d;
  logic [DISP_SIZE-1:0] out_q, out_d;
  logic [SAD_SIZE-1:0]  min_nxt;
  logic [DISP_SIZE-1:0] idx_nxt;
  logic                 accept, last_beat;

  assign disp_valid = (state_q == ST_HOLD);
  assign sad_ready  = !disp_valid || disp_ready;
  assign accept     = sad_valid && sad_ready;
  assign last_beat  = accept && (cnt_q == LAST_D);
  assign disp_out   = out_q;

  wta_compare #(
    .SAD_SIZE  (SAD_SIZE),
    .DISP_SIZE (DISP_SIZE)
  ) u_compare (
    .sad_in  (sad_in),
    .min_cur (min_q),
    .idx_cur (idx_q),
    .d       (cnt_q),
    .min_nxt (min_nxt),
    .idx_nxt (idx_nxt)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    min_d   = min_q;
    idx_d   = idx_q;
    out_d   = out_q;
    if (accept) begin
      min_d = min_nxt;
      idx_d = idx_nxt;
      cnt_d = (cnt_q == LAST_D) ? '0 : cnt_q + DISP_SIZE'(1);
    end
    // A new result outranks retirement of the old one, so disp_valid stays high.
    if (last_beat) begin
      out_d   = idx_nxt;
      state_d = ST_HOLD;
    end else if (disp_valid && disp_ready) begin
      state_d = ST_ACCUM;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q <= ST_ACCUM;
      cnt_q   <= '0;
      min_q   <= '1;
      idx_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      min_q   <= min_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
    end
  end

`ifdef WTA_COST_EN
  logic [SAD_SIZE-1:0] cost_q, cost_d;

  assign cost_d    = last_beat ? min_nxt : cost_q;
  assign disp_cost = cost_q;

  always_ff @(posedge clk) begin
    if (rst) cost_q <= '0;
    else     cost_q <= cost_d;
  end
`endif

endmodule

// File: tb/tb_disparity_wta.sv
// Self-checking bench for disparity_wta (MAX_DISP=4): directed table, corner sequences and
// randomized traffic against a queue-based argmin model. Checks disp_cost when WTA_COST_EN is defined.
module tb_disparity_wta;

  localparam int SAD_SIZE  = 16;
  localparam int MAX_DISP  = 4;
  localparam int DISP_SIZE = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 sad_valid;
  logic                 sad_ready;
  logic [SAD_SIZE-1:0]  sad_in;
  logic                 disp_valid;
  logic                 disp_ready;
  logic [DISP_SIZE-1:0] disp_out;
`ifdef WTA_COST_EN
  logic [SAD_SIZE-1:0]  disp_cost;
`endif

  always #5 clk = ~clk;

  disparity_wta #(
    .SAD_SIZE  (SAD_SIZE),
    .MAX_DISP  (MAX_DISP),
    .DISP_SIZE (DISP_SIZE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sad_valid  (sad_valid),
    .sad_ready  (sad_ready),
    .sad_in     (sad_in),
    .disp_valid (disp_valid),
    .disp_ready (disp_ready),
    .disp_out   (disp_out)
`ifdef WTA_COST_EN
    ,
    .disp_cost  (disp_cost)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: pending result plus the costs accepted so far for the current pixel.
  logic [SAD_SIZE-1:0]  pix_q[$];
  bit                   exp_valid = 1'b0;
  logic [DISP_SIZE-1:0] exp_out   = '0;
  logic [SAD_SIZE-1:0]  exp_cost  = '0;
  int                   results   = 0;

  task automatic tick(input bit v, input logic [SAD_SIZE-1:0] cost, input bit rdy);
    bit acc;
    int best;
    sad_valid  = v;
    sad_in     = cost;
    disp_ready = rdy;
    #1;
    check("sad_ready", 32'(sad_ready), 32'(!exp_valid || rdy));
    check("disp_valid", 32'(disp_valid), 32'(exp_valid));
    if (exp_valid) begin
      check("disp_out", 32'(disp_out), 32'(exp_out));
`ifdef WTA_COST_EN
      check("disp_cost", 32'(disp_cost), 32'(exp_cost));
`endif
    end
    acc = v && (!exp_valid || rdy);
    if (exp_valid && rdy) begin
      exp_valid = 1'b0;
      results++;
    end
    if (acc) begin
      pix_q.push_back(cost);
      if (pix_q.size() == MAX_DISP) begin
        best = 0;
        for (int i = 1; i < MAX_DISP; i++)
          if (pix_q[i] < pix_q[best]) best = i;
        exp_valid = 1'b1;
        exp_out   = DISP_SIZE'(best);
        exp_cost  = pix_q[best];
        pix_q.delete();
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    sad_valid  = 1'b0;
    sad_in     = '0;
    disp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pix_q.delete();
    exp_valid = 1'b0;
    #1;
    check("rst_disp_valid", 32'(disp_valid), 32'd0);
    check("rst_disp_out", 32'(disp_out), 32'd0);
    check("rst_sad_ready", 32'(sad_ready), 32'd1);
`ifdef WTA_COST_EN
    check("rst_disp_cost", 32'(disp_cost), 32'd0);
`endif
    @(negedge clk);
  endtask

  typedef struct packed {
    logic [MAX_DISP-1:0][SAD_SIZE-1:0] c;
    logic [DISP_SIZE-1:0]              d;
    logic [SAD_SIZE-1:0]               cost;
  } vec_t;

  function automatic vec_t mk(input int c0, input int c1, input int c2, input int c3,
                              input int d, input int cost);
    vec_t t;
    t.c[0] = SAD_SIZE'(c0);
    t.c[1] = SAD_SIZE'(c1);
    t.c[2] = SAD_SIZE'(c2);
    t.c[3] = SAD_SIZE'(c3);
    t.d    = DISP_SIZE'(d);
    t.cost = SAD_SIZE'(cost);
    return t;
  endfunction

  task automatic expect_result(input string name, input vec_t t);
    #1;
    check({name, "_valid"}, 32'(disp_valid), 32'd1);
    check({name, "_disp"}, 32'(disp_out), 32'(t.d));
`ifdef WTA_COST_EN
    check({name, "_cost"}, 32'(disp_cost), 32'(t.cost));
`endif
  endtask

  vec_t tbl[6];

  initial begin
    tbl[0] = mk(40, 12, 30, 25, 1, 12);
    tbl[1] = mk(7, 5, 5, 9, 1, 5);
    tbl[2] = mk(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 0, 16'hFFFF);
    tbl[3] = mk(3, 2, 1, 0, 3, 0);
    tbl[4] = mk(9, 8, 7, 6, 3, 6);
    tbl[5] = mk(0, 1, 0, 0, 0, 0);

    do_reset();

    // Directed table: back-to-back beats, result one cycle after the last beat.
    foreach (tbl[k]) begin
      for (int i = 0; i < MAX_DISP; i++) tick(1'b1, tbl[k].c[i], 1'b1);
      expect_result($sformatf("tbl%0d", k), tbl[k]);
      tick(1'b0, '0, 1'b1);
    end

    // Backpressure: result held for 5 cycles while offered beats are refused.
    for (int i = 0; i < MAX_DISP; i++) tick(1'b1, tbl[0].c[i], 1'b0);
    repeat (5) tick(1'b1, 16'd99, 1'b0);
    expect_result("bp_hold", tbl[0]);
    for (int i = 0; i < MAX_DISP; i++) tick(1'b1, tbl[3].c[i], 1'b1);
    expect_result("bp_next", tbl[3]);
    tick(1'b0, '0, 1'b1);

    // Streaming: three pixels with no idle cycles.
    results = 0;
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < MAX_DISP; i++) tick(1'b1, SAD_SIZE'($urandom_range(0, 50)), 1'b1);
    tick(1'b0, '0, 1'b1);
    check("stream_results", 32'(results), 32'd3);

    // Reset in mid-pixel discards the partial search.
    tick(1'b1, 16'd1, 1'b1);
    tick(1'b1, 16'd2, 1'b1);
    do_reset();
    for (int i = 0; i < MAX_DISP; i++) tick(1'b1, tbl[4].c[i], 1'b1);
    expect_result("rst_mid", tbl[4]);
    tick(1'b0, '0, 1'b1);

    // Gaps between every beat.
    begin
      vec_t g;
      g = mk(20, 10, 30, 5, 3, 5);
      for (int i = 0; i < MAX_DISP; i++) begin
        tick(1'b1, g.c[i], 1'b1);
        if (i < MAX_DISP - 1) tick(1'b0, 16'hDEAD, 1'b1);
      end
      expect_result("gaps", g);
      tick(1'b0, '0, 1'b1);
    end

    // Randomized traffic; narrow cost range forces frequent ties.
    for (int n = 0; n < 400; n++) begin
      logic [SAD_SIZE-1:0] c;
      c = ($urandom_range(0, 3) == 0) ? SAD_SIZE'($urandom) : SAD_SIZE'($urandom_range(0, 7));
      tick($urandom_range(0, 3) != 0, c, $urandom_range(0, 9) < 7);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
